// File: rtl/click_pkg.sv
// ---------------------------------------------------------------------------
// click_pkg
// Shared types and constants for the click-channel synchronizing arbiter.
//   arb_state_t          : arbiter FSM encoding (IDLE, ISSUE, WAIT)
//   ARB_RESET_LAST_GRANT : last_grant value after reset, so that requester 0
//                          wins the first tie
// ---------------------------------------------------------------------------
package click_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic ARB_RESET_LAST_GRANT = 1'b1;

endpackage

// File: rtl/ifc_click.sv
// ---------------------------------------------------------------------------
// ifc_click
// Two-phase (transition-signalled) bundled-data click channel.
//
// Handshake: a channel is pending whenever req != ack. The sender puts data
// on the bundle, then toggles req; data must stay stable until the receiver
// toggles ack to equal req, which completes the transaction.
//
//   req  : sender -> receiver, toggles once per transaction
//   ack  : receiver -> sender, toggles to match req on completion
//   data : payload of type T, valid while pending
//
// Modports are named from the arbiter's point of view:
//   in  : the arbiter is the receiver (upstream requesters)
//   out : the arbiter is the sender (downstream sink)
// ---------------------------------------------------------------------------
interface ifc_click #(
  parameter type T = logic
) ();

  logic req;
  logic ack;
  T     data;

  modport in  (input  req, input  data, output ack);
  modport out (output req, output data, input  ack);

endinterface

// File: rtl/click_sync.sv
// ---------------------------------------------------------------------------
// click_sync
// N-flop synchronizer with asynchronous active-low reset. Brings a
// transition-signalled req or ack from an asynchronous neighbour into the
// clk domain. All flops clear to 0 on reset, matching the reset phase of the
// click channels.
//
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output (N clk edges of latency)
// ---------------------------------------------------------------------------
module click_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d};
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/click_sync_arbiter.sv
// ---------------------------------------------------------------------------
// click_sync_arbiter
// Round-robin arbiter that merges two asynchronous 2-phase click requesters
// onto one shared downstream click channel, using a single local clock.
//
// Parameters:
//   T           : payload type carried on all channels
//   SYNC_STAGES : flop depth of each req/ack synchronizer (2..4)
//
// Ports:
//   clk   : sole clock
//   rst_n : asynchronous active-low reset
//   in0   : requester 0 (arbiter receives, drives in0.ack)
//   in1   : requester 1 (arbiter receives, drives in1.ack)
//   out   : shared downstream channel (arbiter drives out.req / out.data)
//
// Operation: IDLE picks a winner among the pending requesters and registers
// its data; ISSUE toggles out.req one cycle later so data leads req; WAIT
// holds everything until the synchronized out.ack matches out.req, then
// toggles the winner's ack and returns to IDLE. Every output is a flop.
// ---------------------------------------------------------------------------
module click_sync_arbiter
  import click_pkg::*;
#(
  parameter type T           = logic,
  parameter int  SYNC_STAGES = 2
) (
  input logic   clk,
  input logic   rst_n,
  ifc_click.in  in0,
  ifc_click.in  in1,
  ifc_click.out out
);

  // Synchronized views of the asynchronous inputs.
  logic req0_s;
  logic req1_s;
  logic ack_s;

  click_sync #(.N(SYNC_STAGES)) u_sync_req0 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in0.req),
    .q     (req0_s)
  );

  click_sync #(.N(SYNC_STAGES)) u_sync_req1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in1.req),
    .q     (req1_s)
  );

  click_sync #(.N(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out.ack),
    .q     (ack_s)
  );

  arb_state_t state_q;
  logic       grant_q;       // requester currently being served
  logic       last_grant_q;  // requester served most recently
  logic       out_req_q;
  T           out_data_q;
  logic       ack0_q;
  logic       ack1_q;

  // Pending is level-based: a request arriving while the other input is
  // being served simply stays pending until IDLE looks again.
  logic pend0;
  logic pend1;
  logic winner;
  T     win_data;

  assign pend0 = req0_s ^ ack0_q;
  assign pend1 = req1_s ^ ack1_q;

  always_comb begin
    winner = 1'b0;
    if (pend0 && pend1) begin
      winner = ~last_grant_q;
    end else if (pend1) begin
      winner = 1'b1;
    end
  end

  assign win_data = winner ? in1.data : in0.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= ARB_RESET_LAST_GRANT;
      out_req_q    <= 1'b0;
      out_data_q   <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend0 || pend1) begin
            out_data_q <= win_data;
            grant_q    <= winner;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // Data was registered on the previous edge, so it is already
          // stable on the bundle when req transitions.
          out_req_q <= ~out_req_q;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (ack_s == out_req_q) begin
            // Completing the upstream handshake makes the winner's
            // synchronized req equal its ack, so it cannot be re-granted
            // on the next IDLE cycle.
            if (grant_q) begin
              ack1_q <= ~ack1_q;
            end else begin
              ack0_q <= ~ack0_q;
            end
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out.req  = out_req_q;
  assign out.data = out_data_q;
  assign in0.ack  = ack0_q;
  assign in1.ack  = ack1_q;

endmodule
